// File: rtl/o_mem_reader.sv
// Drain engine for ai_top's output memory: reads a burst of result words over the
// synchronous o_mem read port and streams them out on a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing o_mem reads, throttled by skid FIFO space
// DRAIN | all reads issued, emptying FIFO until the o_last word is taken
// FIN   | one-cycle done pulse
module o_mem_reader #(
    parameter int WIDTH  = 32,
    parameter int N_OUT  = 2,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          count,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [N_OUT*WIDTH-1:0]   mem_q,
    output logic [N_OUT*WIDTH-1:0]   o_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic                     o_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam logic [ADDR_W:0] LEFT_ONE = 1;

    state_t                   state;
    logic [ADDR_W:0]          rd_left;
    logic [ADDR_W-1:0]        addr_q;
    logic                     inflight;
    logic                     inflight_last;

    logic [N_OUT*WIDTH-1:0]   fifo_data [2];
    logic [1:0]               fifo_last;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               fifo_cnt;

    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [2:0]               occ;

    assign pop   = o_valid & o_ready;
    assign push  = inflight;
    assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight};
    // A read may only issue if the FIFO can still hold it once it returns,
    // counting the word leaving this cycle.
    assign issue = (state == READ) && (occ < (3'd2 + {2'b00, pop}));

    assign mem_rd   = issue;
    assign mem_addr = addr_q;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign o_valid  = (fifo_cnt != 2'd0);
    assign o_data   = fifo_data[rd_ptr];
    assign o_last   = o_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rd_left       <= '0;
            addr_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rd_left == LEFT_ONE);
            if (issue) begin
                addr_q  <= addr_q + 1'b1;
                rd_left <= rd_left - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        rd_left <= count;
                        state   <= (count == '0) ? FIN : READ;
                    end
                end
                READ: begin
                    if (issue && (rd_left == LEFT_ONE))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && o_last)
                        state <= FIN;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++)
                fifo_data[i] <= '0;
            fifo_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_q;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
